pipe_stage_reg: RTL

- Parametrised elastic pipeline stage register. It is the successor to the fixed 4×32-bit EX/MEM latch in the pipelined MIPS CPU.
- Carries NUM_CH lanes of DATA_W bits (e.g. V2, IR, AO, PC8) between stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, plus synchronous flush for bubble insertion.
- Adds a saturating stall-cycle counter for performance debug.
- Sits between any two pipeline stages (D/E, E/M, M/W).

---
 rtl/pipe_stage_reg.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised elastic pipeline stage register with a valid/ready handshake
// and a two-entry (main + skid) buffer.
//
// It carries NUM_CH lanes of DATA_W bits between two pipeline stages and
// provides:
//   - a synchronous flush for bubble insertion
//   - a saturating counter of stalled output cycles, for performance debug
//
// Parameters
//   NUM_CH      number of data lanes carried
//   DATA_W      width of each lane in bits
//   BUBBLE_ZERO 1: out_data reads 0 while out_valid=0 (IR=0 is a nop)
//               0: out_data holds its last main value
//   CNT_W       width of the stall counter
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   upstream presents valid data
//   in_ready   stage can accept data this cycle (registered)
//   in_data    lane k occupies bits [k*DATA_W +: DATA_W]
//   flush      synchronous kill of held entries and of the current input
//   out_valid  main entry holds valid data
//   out_ready  downstream accepts out_data this cycle
//   out_data   main entry data
//   occupancy  number of valid entries held, 0..2
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int BUBBLE_ZERO = 1,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int BUS_W = NUM_CH * DATA_W;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occState_t;

    occState_t        r_occ;
    occState_t        w_occNext;
    logic [BUS_W-1:0] r_mainData;
    logic [BUS_W-1:0] w_mainNext;
    logic [BUS_W-1:0] r_skidData;
    logic [BUS_W-1:0] w_skidNext;
    logic             r_inReady;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] w_stallNext;
    logic             w_outValid;
    logic             w_accept;
    logic             w_drain;

    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    assign w_outValid = (r_occ != OCC_EMPTY);
    assign w_accept   = in_valid & r_inReady;
    assign w_drain    = w_outValid & out_ready;

    // Next occupancy and entry contents. in_ready is 0 whenever the skid is
    // full, so OCC_FULL never sees an accept and only has to handle a drain.
    always_comb begin
        w_occNext  = r_occ;
        w_mainNext = r_mainData;
        w_skidNext = r_skidData;

        if (flush) begin
            w_occNext = OCC_EMPTY;
            if (BUBBLE_ZERO != 0) begin
                w_mainNext = '0;
                w_skidNext = '0;
            end
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        w_mainNext = in_data;
                        w_occNext  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_drain) begin
                        w_mainNext = in_data;
                    end else if (w_accept) begin
                        w_skidNext = in_data;
                        w_occNext  = OCC_FULL;
                    end else if (w_drain) begin
                        w_occNext = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (w_drain) begin
                        w_mainNext = r_skidData;
                        w_occNext  = OCC_ONE;
                    end
                end
                default: begin
                    w_occNext = OCC_EMPTY;
                end
            endcase
        end
    end

    // The stall counter watches the output side only, so it keeps counting
    // through a flush cycle and is cleared by reset alone.
    always_comb begin
        w_stallNext = r_stallCnt;
        if (w_outValid && !out_ready && (r_stallCnt != STALL_MAX)) begin
            w_stallNext = r_stallCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ      <= OCC_EMPTY;
            r_mainData <= '0;
            r_skidData <= '0;
            r_inReady  <= 1'b1;
            r_stallCnt <= '0;
        end else begin
            r_occ      <= w_occNext;
            r_mainData <= w_mainNext;
            r_skidData <= w_skidNext;
            r_inReady  <= (w_occNext != OCC_FULL);
            r_stallCnt <= w_stallNext;
        end
    end

    // A bubble is masked at the output rather than by clearing the main
    // register on every drain, so the register only changes on a real load.
    always_comb begin
        out_data = r_mainData;
        if ((BUBBLE_ZERO != 0) && !w_outValid) begin
            out_data = '0;
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = w_outValid;
    assign occupancy = r_occ;
    assign stall_cnt = r_stallCnt;

endmodule
